jtopl_eg_sched: RTL and testbench

Per-slot envelope step scheduler for the OPL envelope generator. It owns the 18-slot time-division sequence, generates the once-per-frame `zero` strobe that advances the 15-bit global envelope counter, and converts each slot's 6-bit effective rate into a registered `step`/`inc` decision. It sits between the operator register bank, which supplies the rate for the addressed slot, and the per-slot attenuation update logic, which consumes `step`/`inc`.

---
 rtl/jtopl_pkg.sv | 28 ++
 rtl/jtopl_eg_cnt.sv | 24 ++
 rtl/jtopl_eg_sched.sv | 93 +++++++++
 tb/tb_jtopl_eg_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_pkg.sv
// Shared constants and helpers for the OPL envelope generator: slot and rate widths,
// the four step-density patterns, and the rate-to-counter-shift mapping.
package jtopl_pkg;

    localparam int SLOT_W = 5;
    localparam int RATE_W = 6;

    localparam logic [7:0] STEP_PAT0 = 8'b10101010;
    localparam logic [7:0] STEP_PAT1 = 8'b11101010;
    localparam logic [7:0] STEP_PAT2 = 8'b11101110;
    localparam logic [7:0] STEP_PAT3 = 8'b11111110;

    // Only meaningful for rates 1..47; faster rates bypass the shift entirely.
    function automatic logic [3:0] rate_shift(input logic [RATE_W-1:0] rate);
        rate_shift = 4'd11 - rate[5:2];
    endfunction

    function automatic logic [7:0] step_pattern(input logic [1:0] sel);
        case (sel)
            2'd0:    step_pattern = STEP_PAT0;
            2'd1:    step_pattern = STEP_PAT1;
            2'd2:    step_pattern = STEP_PAT2;
            2'd3:    step_pattern = STEP_PAT3;
            default: step_pattern = STEP_PAT0;
        endcase
    endfunction

endpackage

// File: rtl/jtopl_eg_cnt.sv
// Global 15-bit envelope counter; advances once per frame on the slot-0 strobe
// and wraps silently.
module jtopl_eg_cnt (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        zero,
    output logic [14:0] eg_cnt
);

    logic [14:0] cnt_q;

    // Frame counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 15'd0;
        end else if (cen && zero) begin
            cnt_q <= cnt_q + 15'd1;
        end
    end

    assign eg_cnt = cnt_q;

endmodule

// File: rtl/jtopl_eg_sched.sv
// Envelope step scheduler: walks the slot sequence, drives the envelope counter and
// registers the per-slot step/increment decision one cen edge after the slot is addressed.
module jtopl_eg_sched
    import jtopl_pkg::*;
#(
    parameter int SLOTS = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              restart,
    input  logic [RATE_W-1:0] rate_in,
    output logic [SLOT_W-1:0] slot,
    output logic              zero,
    output logic [14:0]       eg_cnt,
    output logic              step,
    output logic [2:0]        inc,
    output logic [SLOT_W-1:0] step_slot
);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [SLOT_W-1:0] step_slot_q;
    logic              step_q, step_d;
    logic [2:0]        inc_q, inc_d;
    logic [14:0]       eg_cnt_s;
    logic [3:0]        sh_s;
    logic [14:0]       mask_s;
    logic [2:0]        idx_s;
    logic [7:0]        pat_s;
    logic              cnt_ok_s;

    jtopl_eg_cnt u_eg_cnt (
        .rst    (rst),
        .clk    (clk),
        .cen    (cen),
        .zero   (zero),
        .eg_cnt (eg_cnt_s)
    );

    // Slot sequencing: wrap at the last slot or on restart.
    always_comb begin
        slot_d = slot_q + {{(SLOT_W-1){1'b0}}, 1'b1};
        if (restart || (slot_q == SLOT_W'(SLOTS - 1))) begin
            slot_d = {SLOT_W{1'b0}};
        end else begin
            slot_d = slot_q + {{(SLOT_W-1){1'b0}}, 1'b1};
        end
    end

    // Step decode for the addressed slot against the current frame count.
    always_comb begin
        step_d   = 1'b0;
        inc_d    = 3'd0;
        sh_s     = rate_shift(rate_in);
        mask_s   = (15'd1 << sh_s) - 15'd1;
        cnt_ok_s = ((eg_cnt_s & mask_s) == 15'd0);
        idx_s    = 3'(eg_cnt_s >> sh_s);
        pat_s    = step_pattern(rate_in[1:0]);
        if (rate_in == 6'd0) begin
            step_d = 1'b0;
            inc_d  = 3'd0;
        end else if (rate_in[5:4] == 2'b11) begin
            step_d = 1'b1;
            inc_d  = 3'(rate_in[5:2] - 4'd11);
        end else begin
            step_d = cnt_ok_s & pat_s[idx_s];
            inc_d  = {2'b00, step_d};
        end
    end

    // Slot counter and registered step outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= {SLOT_W{1'b0}};
            step_q      <= 1'b0;
            inc_q       <= 3'd0;
            step_slot_q <= {SLOT_W{1'b0}};
        end else if (cen) begin
            slot_q      <= slot_d;
            step_q      <= step_d;
            inc_q       <= inc_d;
            step_slot_q <= slot_q;
        end
    end

    assign slot      = slot_q;
    assign zero      = (slot_q == {SLOT_W{1'b0}});
    assign eg_cnt    = eg_cnt_s;
    assign step      = step_q;
    assign inc       = inc_q;
    assign step_slot = step_slot_q;

endmodule

// File: tb/tb_jtopl_eg_sched.sv
// Self-checking bench for jtopl_eg_sched: a per-edge reference model of the scheduler
// rules plus directed literal checks of counts, latency, restart and reset behaviour.
module tb_jtopl_eg_sched;

    localparam int NSLOT = 18;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        restart;
    logic [5:0]  rate_in;
    logic [4:0]  slot;
    logic        zero;
    logic [14:0] eg_cnt;
    logic        step;
    logic [2:0]  inc;
    logic [4:0]  step_slot;

    logic [5:0]  rate_tab [0:31];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int m_slot, m_cnt, m_step, m_inc, m_sslot;

    jtopl_eg_sched #(.SLOTS(NSLOT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .restart   (restart),
        .rate_in   (rate_in),
        .slot      (slot),
        .zero      (zero),
        .eg_cnt    (eg_cnt),
        .step      (step),
        .inc       (inc),
        .step_slot (step_slot)
    );

    // The register bank answers for whatever slot the scheduler addresses.
    assign rate_in = rate_tab[slot];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {step, inc[2:0]} from the rate/counter rules.
    function automatic logic [3:0] exp_dec(input int rate, input int cnt);
        int sh, idx, pat;
        int pats [4] = '{8'hAA, 8'hEA, 8'hEE, 8'hFE};
        if (rate == 0) return 4'd0;
        if (rate >= 48) return {1'b1, 3'(rate / 4 - 11)};
        sh = 11 - rate / 4;
        if ((cnt % (1 << sh)) != 0) return 4'd0;
        idx = (cnt >> sh) % 8;
        pat = pats[rate % 4];
        if (((pat >> idx) & 1) == 1) return 4'b1001;
        return 4'd0;
    endfunction

    // Reference model, one update per enabled edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_slot  <= 0;
            m_cnt   <= 0;
            m_step  <= 0;
            m_inc   <= 0;
            m_sslot <= 0;
        end else if (cen) begin
            logic [3:0] d;
            d = exp_dec(int'(rate_tab[m_slot]), m_cnt);
            m_step  <= int'(d[3]);
            m_inc   <= int'(d[2:0]);
            m_sslot <= m_slot;
            m_cnt   <= (m_slot == 0) ? ((m_cnt + 1) % 32768) : m_cnt;
            m_slot  <= (restart || m_slot == NSLOT - 1) ? 0 : m_slot + 1;
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("slot",      32'(slot),      32'(m_slot));
            check("zero",      32'(zero),      32'(m_slot == 0));
            check("eg_cnt",    32'(eg_cnt),    32'(m_cnt));
            check("step",      32'(step),      32'(m_step));
            check("inc",       32'(inc),       32'(m_inc));
            check("step_slot", 32'(step_slot), 32'(m_sslot));
        end
    end

    task automatic fill_rates(input logic [5:0] r);
        for (int i = 0; i < 32; i++) rate_tab[i] = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cen = 1'b0;
        restart = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cen = 1'b1;
    endtask

    initial begin
        int nstep;
        rst = 1'b1;
        cen = 1'b0;
        restart = 1'b0;
        fill_rates(6'd0);
        #12;
        check("rst_slot",      32'(slot),      32'd0);
        check("rst_zero",      32'(zero),      32'd1);
        check("rst_eg_cnt",    32'(eg_cnt),    32'd0);
        check("rst_step",      32'(step),      32'd0);
        check("rst_inc",       32'(inc),       32'd0);
        check("rst_step_slot", 32'(step_slot), 32'd0);
        chk_en = 1'b1;

        // Two full frames
        do_reset();
        repeat (36) @(posedge clk);
        @(negedge clk);
        check("frames2_slot",   32'(slot),   32'd0);
        check("frames2_eg_cnt", 32'(eg_cnt), 32'd2);

        // Rate 0 across 1000 frames never steps
        nstep = 0;
        repeat (1000 * NSLOT) begin
            @(negedge clk);
            if (step !== 1'b0 || inc !== 3'd0) nstep++;
        end
        check("rate0_steps", 32'(nstep), 32'd0);

        // Fast rates
        fill_rates(6'd60);
        repeat (2) @(negedge clk);
        check("rate60_step", 32'(step), 32'd1);
        check("rate60_inc",  32'(inc),  32'd4);
        fill_rates(6'd50);
        repeat (2) @(negedge clk);
        check("rate50_step", 32'(step), 32'd1);
        check("rate50_inc",  32'(inc),  32'd1);

        // Restart at slot 9
        fill_rates(6'd0);
        do_reset();
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("pre_restart_slot", 32'(slot),   32'd9);
        check("pre_restart_cnt",  32'(eg_cnt), 32'd1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_slot",      32'(slot),      32'd0);
        check("restart_cnt",       32'(eg_cnt),    32'd1);
        check("restart_step_slot", 32'(step_slot), 32'd9);

        // Rate 4 sweep over eg_cnt 0..16383 using back-to-back restarts
        fill_rates(6'd4);
        do_reset();
        restart = 1'b1;
        nstep = 0;
        repeat (16384) begin
            @(negedge clk);
            if (step === 1'b1) nstep++;
        end
        restart = 1'b0;
        check("rate4_step_count", 32'(nstep),  32'd8);
        check("rate4_sweep_cnt",  32'(eg_cnt), 32'd16384);

        // Mixed rates per slot over many frames
        for (int i = 0; i < 32; i++) rate_tab[i] = 6'((i * 7 + 3) % 64);
        rate_tab[0] = 6'd13;
        rate_tab[5] = 6'd47;
        rate_tab[6] = 6'd1;
        repeat (300 * NSLOT + 7) @(negedge clk);

        // Freeze with cen low, then async reset mid-cycle
        cen = 1'b0;
        repeat (50) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_slot",      32'(slot),      32'd0);
        check("arst_zero",      32'(zero),      32'd1);
        check("arst_eg_cnt",    32'(eg_cnt),    32'd0);
        check("arst_step",      32'(step),      32'd0);
        check("arst_inc",       32'(inc),       32'd0);
        check("arst_step_slot", 32'(step_slot), 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        cen = 1'b1;
        @(negedge clk);
        check("post_rst_slot", 32'(slot),   32'd1);
        check("post_rst_cnt",  32'(eg_cnt), 32'd1);
        repeat (3 * NSLOT) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
